// File: rtl/definitions.sv
// definitions: shared ALU opcode encodings for the datapath.
// Provides the 3-bit Function codes consumed by the combinational ALU and by
// any initiator that drives it (e.g. alu_mul_sequencer).
package definitions;
  localparam logic [2:0] kADD = 3'd0;
  localparam logic [2:0] kAND = 3'd1;
  localparam logic [2:0] kSLL = 3'd2;
  localparam logic [2:0] kSRL = 3'd3;
  localparam logic [2:0] kEQ  = 3'd4;
endpackage

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: multi-cycle 8x8 shift-and-add multiplier (low byte of
// A*B) that performs all arithmetic by issuing operations to the shared
// combinational ALU and capturing its result at each clock edge.
//
// Optional feature macro: ALU_SEQ_EARLY_EXIT_EN
//   defined   - stop iterating as soon as the remaining multiplier is zero.
//   undefined - always run exactly 8 iterations (data-independent latency
//               except for the ADD cycles), tracked by a 4-bit counter.
//
// Ports:
//   CLK            in   clock, rising edge
//   Reset_n        in   asynchronous active-low reset
//   Start          in   request a multiply (sampled only when idle)
//   OperandA[7:0]  in   multiplicand, latched on accepted Start
//   OperandB[7:0]  in   multiplier, latched on accepted Start
//   Busy           out  high whenever not idle
//   Done           out  one-cycle pulse in the final state
//   Product[7:0]   out  low byte of A*B, held until the next result
//   AluA[7:0]      out  ALU InputA
//   AluB[7:0]      out  ALU InputB
//   AluFunction[2:0] out ALU Function
//   AluOut[7:0]    in   ALU Out
//   AluTakeBranch  in   ALU takeBranch (Out[0])
module alu_mul_sequencer
  import definitions::*;
(
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       Start,
  input  logic [7:0] OperandA,
  input  logic [7:0] OperandB,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Product,
  output logic [7:0] AluA,
  output logic [7:0] AluB,
  output logic [2:0] AluFunction,
  input  logic [7:0] AluOut,
  input  logic       AluTakeBranch
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ZCHK = 3'd1;
  localparam logic [2:0] S_TEST = 3'd2;
  localparam logic [2:0] S_ADD  = 3'd3;
  localparam logic [2:0] S_SHL  = 3'd4;
  localparam logic [2:0] S_SHR  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0] state;
  logic [7:0] m;      // multiplicand, shifted left each iteration
  logic [7:0] q;      // multiplier, shifted right each iteration
  logic [7:0] p;      // partial-product accumulator
`ifndef ALU_SEQ_EARLY_EXIT_EN
  logic [3:0] iter;
`endif

  assign Busy = (state != S_IDLE);
  assign Done = (state == S_DONE);

  // ALU drive is purely a function of the current state and the datapath
  // registers; the result comes back combinationally in the same cycle.
  always_comb begin
    AluFunction = kADD;
    AluA        = 8'h00;
    AluB        = 8'h00;
    case (state)
      S_ZCHK: begin AluFunction = kEQ;  AluA = q; AluB = 8'h00; end
      S_TEST: begin AluFunction = kAND; AluA = q; AluB = 8'h01; end
      S_ADD:  begin AluFunction = kADD; AluA = p; AluB = m;     end
      S_SHL:  begin AluFunction = kSLL; AluA = m; AluB = 8'h01; end
      S_SHR:  begin AluFunction = kSRL; AluA = q; AluB = 8'h00; end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= S_IDLE;
      m       <= 8'h00;
      q       <= 8'h00;
      p       <= 8'h00;
      Product <= 8'h00;
`ifndef ALU_SEQ_EARLY_EXIT_EN
      iter    <= 4'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            m     <= OperandA;
            q     <= OperandB;
            p     <= 8'h00;
`ifndef ALU_SEQ_EARLY_EXIT_EN
            iter  <= 4'd0;
`endif
            state <= S_ZCHK;
          end
        end
        S_ZCHK: begin
`ifdef ALU_SEQ_EARLY_EXIT_EN
          // ALU compare (q == 0) ends the loop once no multiplier bits remain.
          state <= AluTakeBranch ? S_DONE : S_TEST;
`else
          // Fixed 8 iterations; the ALU compare result is deliberately unused.
          state <= (iter == 4'd8) ? S_DONE : S_TEST;
`endif
        end
        S_TEST: state <= AluTakeBranch ? S_ADD : S_SHL;
        S_ADD: begin
          p     <= AluOut;
          state <= S_SHL;
        end
        S_SHL: begin
          m     <= AluOut;
          state <= S_SHR;
        end
        S_SHR: begin
          q     <= AluOut;
`ifndef ALU_SEQ_EARLY_EXIT_EN
          iter  <= iter + 4'd1;
`endif
          state <= S_ZCHK;
        end
        S_DONE: begin
          Product <= p;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: self-checking bench for alu_mul_sequencer with a
// behavioural ALU and a reference model of the multiply algorithm.
module tb_alu_mul_sequencer;
  import definitions::*;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] OperandA = 8'h00;
  logic [7:0] OperandB = 8'h00;
  logic       Busy, Done;
  logic [7:0] Product, AluA, AluB, AluOut;
  logic [2:0] AluFunction;
  logic       AluTakeBranch;

  int n_checks = 0;
  int n_pass   = 0;

  logic [18:0] exp_q[$];

  always #5 CLK = ~CLK;

  alu_mul_sequencer dut (
    .CLK(CLK), .Reset_n(Reset_n), .Start(Start),
    .OperandA(OperandA), .OperandB(OperandB),
    .Busy(Busy), .Done(Done), .Product(Product),
    .AluA(AluA), .AluB(AluB), .AluFunction(AluFunction),
    .AluOut(AluOut), .AluTakeBranch(AluTakeBranch)
  );

  // Behavioural ALU: shifts are single-bit, B ignored for shifts.
  always_comb begin
    AluOut = 8'h00;
    case (AluFunction)
      kADD: AluOut = AluA + AluB;
      kAND: AluOut = AluA & AluB;
      kSLL: AluOut = {AluA[6:0], 1'b0};
      kSRL: AluOut = {1'b0, AluA[7:1]};
      kEQ:  AluOut = (AluA == AluB) ? 8'h01 : 8'h00;
      default: AluOut = 8'h00;
    endcase
  end
  assign AluTakeBranch = AluOut[0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Expected per-cycle ALU transcript, derived from the algorithm description.
  task automatic build_transcript(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] mm, qq, pp;
    mm = a; qq = b; pp = 8'h00;
    exp_q.delete();
    exp_q.push_back({kEQ, qq, 8'h00});
    for (int i = 0; i < 8; i++) begin
`ifdef ALU_SEQ_EARLY_EXIT_EN
      if (qq == 8'h00) break;
`endif
      exp_q.push_back({kAND, qq, 8'h01});
      if (qq[0]) begin
        exp_q.push_back({kADD, pp, mm});
        pp = pp + mm;
      end
      exp_q.push_back({kSLL, mm, 8'h01});
      mm = mm << 1;
      exp_q.push_back({kSRL, qq, 8'h00});
      qq = qq >> 1;
      exp_q.push_back({kEQ, qq, 8'h00});
    end
    exp_q.push_back({kADD, 8'h00, 8'h00});
  endtask

  function automatic int latency_of(input logic [7:0] b);
    int iters;
`ifdef ALU_SEQ_EARLY_EXIT_EN
    iters = $clog2(int'(b) + 1);
`else
    iters = 8;
`endif
    return 2 + 4 * iters + $countones(b);
  endfunction

  // Called at posedge+1 with the DUT idle. poke=1 raises Start (A=B=9)
  // for one cycle mid-operation, which must be ignored.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke);
    int lat, done_cyc;
    logic [7:0] exp_prod;
    lat = latency_of(b);
    exp_prod = 8'(int'(a) * int'(b));
    build_transcript(a, b);
    Start = 1'b1; OperandA = a; OperandB = b;
    @(posedge CLK); #1;
    Start = 1'b0; OperandA = 8'($urandom); OperandB = 8'($urandom);
    done_cyc = 0;
    for (int c = 1; c <= 64; c++) begin
      Start = poke && (c == 5);
      if (poke && c == 5) begin OperandA = 8'd9; OperandB = 8'd9; end
      if (c <= exp_q.size())
        check_eq($sformatf("alu_drive c%0d", c), {13'd0, AluFunction, AluA, AluB}, {13'd0, exp_q[c-1]});
      check_eq("busy", {31'd0, Busy}, 32'd1);
      check_eq($sformatf("done c%0d", c), {31'd0, Done}, {31'd0, (c == lat)});
      if (Done) done_cyc = c;
      @(posedge CLK); #1;
      Start = 1'b0;
      if (done_cyc != 0) break;
    end
    check_eq("latency", done_cyc, lat);
    check_eq("idle_busy", {31'd0, Busy}, 32'd0);
    check_eq("product", {24'd0, Product}, {24'd0, exp_prod});
    @(posedge CLK); #1;
    check_eq("product_hold", {24'd0, Product}, {24'd0, exp_prod});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    // Reset state, still in reset.
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_done", {31'd0, Done}, 32'd0);
    check_eq("rst_product", {24'd0, Product}, 32'd0);
    check_eq("rst_alu", {13'd0, AluFunction, AluA, AluB}, {13'd0, kADD, 16'h0000});
    Reset_n = 1'b1;
    @(posedge CLK); #1;
    check_eq("idle_busy0", {31'd0, Busy}, 32'd0);

    // Directed cases.
    run_op(8'd5,   8'd3,  1'b0);
    run_op(8'd13,  8'd20, 1'b0);
    run_op(8'hFF,  8'd0,  1'b0);
    run_op(8'd3,   8'd1,  1'b0);
    run_op(8'hFF,  8'hFF, 1'b0);
    run_op(8'd7,   8'd2,  1'b1);   // Start while busy is ignored
    run_op(8'd9,   8'd9,  1'b0);

    // Randomised operations.
    for (int i = 0; i < 20; i++) run_op(8'($urandom), 8'($urandom), 1'b0);

    // Reset during the second ADD of 7*3 (cycle 8: P=7, M=14).
    Start = 1'b1; OperandA = 8'd7; OperandB = 8'd3;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (7) begin @(posedge CLK); #1; end
    check_eq("pre_rst_alu", {13'd0, AluFunction, AluA, AluB}, {13'd0, kADD, 8'd7, 8'd14});
    Reset_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, Busy}, 32'd0);
    check_eq("midrst_alu", {13'd0, AluFunction, AluA, AluB}, {13'd0, kADD, 16'h0000});
    @(posedge CLK); #1;
    Reset_n = 1'b1;
    repeat (3) begin @(posedge CLK); #1; end
    check_eq("post_rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("post_rst_product", {24'd0, Product}, 32'd0);
    run_op(8'd6, 8'd7, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
